// File: rtl/display_scan_driver.sv
// HUB75-style scan driver: reads the front buffer row by row and shifts one BCM
// plane at a time to the panel, latching and lighting each plane for oe_base<<plane cycles.
module display_scan_driver #(
    parameter int rows    = 8,
    parameter int columns = 32,
    parameter int bits    = 8,
    parameter int oe_base = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    output logic [$clog2(rows)-1:0]    rrow,
    output logic [$clog2(columns)-1:0] rcol,
    input  logic [23:0]                rdata,
    output logic                       panel_clk,
    output logic                       panel_lat,
    output logic                       panel_oe_n,
    output logic [$clog2(rows)-1:0]    panel_addr,
    output logic                       panel_r,
    output logic                       panel_g,
    output logic                       panel_b,
    output logic                       frame_done
);

    localparam int RW = $clog2(rows);
    localparam int CW = $clog2(columns);
    localparam int PW = (bits > 1) ? $clog2(bits) : 1;
    localparam int SW = $clog2(2 * columns + 1);
    localparam int DW = bits + $clog2(oe_base) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   scnt, scnt_n;
    logic [DW-1:0]   dcnt, dcnt_n, olen;
    logic [RW-1:0]   row, row_n;
    logic [PW-1:0]   plane, plane_n;
    logic [bits-1:0] rch, gch, bch;

    logic [RW-1:0]   rrow_n, addr_n;
    logic [CW-1:0]   rcol_n;
    logic            pclk_n, lat_n, oe_n_n, fd_n;
    logic            r_n, g_n, b_n;

    assign rch = rdata[16 +: bits];
    assign gch = rdata[8 +: bits];
    assign bch = rdata[0 +: bits];

    // Outputs are registered from the next-state values so each output
    // reflects the state/step it belongs to in the same cycle.
    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        dcnt_n  = dcnt;
        row_n   = row;
        plane_n = plane;
        olen    = DW'(oe_base) << plane;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = SHIFT;
                    scnt_n  = '0;
                    row_n   = '0;
                    plane_n = '0;
                end
            end
            SHIFT: begin
                if (scnt == SW'(2 * columns)) state_n = LATCH;
                else                          scnt_n  = scnt + SW'(1);
            end
            LATCH: begin
                state_n = DISPLAY;
                dcnt_n  = '0;
            end
            DISPLAY: begin
                if (dcnt == olen - DW'(1)) begin
                    scnt_n = '0;
                    if (plane == PW'(bits - 1)) begin
                        plane_n = '0;
                        row_n   = (row == RW'(rows - 1)) ? '0 : row + RW'(1);
                    end else begin
                        plane_n = plane + PW'(1);
                    end
                    if (enable) begin
                        state_n = SHIFT;
                    end else begin
                        state_n = IDLE;
                        row_n   = '0;
                        plane_n = '0;
                    end
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        rrow_n = rrow;
        rcol_n = rcol;
        if (state_n == SHIFT && !scnt_n[0] && scnt_n < SW'(2 * columns)) begin
            rrow_n = row_n;
            rcol_n = CW'(scnt_n >> 1);
        end
        pclk_n = (state_n == SHIFT) && !scnt_n[0] && (scnt_n != '0);
        lat_n  = (state_n == LATCH);
        addr_n = (state_n == LATCH) ? row_n : panel_addr;
        oe_n_n = (state_n != DISPLAY);
        fd_n   = (state_n == DISPLAY) && (dcnt_n == olen - DW'(1)) &&
                 (row_n == RW'(rows - 1)) && (plane_n == PW'(bits - 1));

        r_n = panel_r;
        g_n = panel_g;
        b_n = panel_b;
        if (state == SHIFT && scnt[0]) begin
            r_n = rch[plane];
            g_n = gch[plane];
            b_n = bch[plane];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            scnt       <= '0;
            dcnt       <= '0;
            row        <= '0;
            plane      <= '0;
            rrow       <= '0;
            rcol       <= '0;
            panel_clk  <= 1'b0;
            panel_lat  <= 1'b0;
            panel_oe_n <= 1'b1;
            panel_addr <= '0;
            panel_r    <= 1'b0;
            panel_g    <= 1'b0;
            panel_b    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            scnt       <= scnt_n;
            dcnt       <= dcnt_n;
            row        <= row_n;
            plane      <= plane_n;
            rrow       <= rrow_n;
            rcol       <= rcol_n;
            panel_clk  <= pclk_n;
            panel_lat  <= lat_n;
            panel_oe_n <= oe_n_n;
            panel_addr <= addr_n;
            panel_r    <= r_n;
            panel_g    <= g_n;
            panel_b    <= b_n;
            frame_done <= fd_n;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: random frame buffer behind a 1-cycle read model,
// panel activity reduced to edge/latch/OE-run/frame events and compared to expectations.
module tb_display_scan_driver;

    localparam int ROWS  = 8;
    localparam int COLS  = 32;
    localparam int BITS  = 8;
    localparam int FRAME = ROWS * (BITS * (2 * COLS + 2) + (2 ** BITS - 1));

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  rrow, panel_addr;
    logic [4:0]  rcol;
    logic [23:0] rdata = '0;
    logic        panel_clk, panel_lat, panel_oe_n, panel_r, panel_g, panel_b, frame_done;

    display_scan_driver #(.rows(ROWS), .columns(COLS), .bits(BITS), .oe_base(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rrow(rrow), .rcol(rcol), .rdata(rdata),
        .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
        .panel_addr(panel_addr), .panel_r(panel_r), .panel_g(panel_g), .panel_b(panel_b),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [23:0] mem [ROWS][COLS];
    always @(posedge clk) rdata <= mem[rrow][rcol];

    int total = 0;
    int bad   = 0;

    logic [2:0] edgeq[$];
    int latq[$], cntq[$], oeq[$], fdq[$];
    int cyc = 0, run = 0, ecnt = 0, total_edges = 0, total_lats = 0, addr_viol = 0;
    logic prev_pclk = 1'b0, prev_oe_low = 1'b0;
    logic [2:0] prev_addr = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_pclk   = 1'b0;
            prev_oe_low = 1'b0;
            run         = 0;
            ecnt        = 0;
            prev_addr   = panel_addr;
        end else begin
            if (panel_clk && !prev_pclk) begin
                edgeq.push_back({panel_r, panel_g, panel_b});
                ecnt++;
                total_edges++;
            end
            prev_pclk = panel_clk;
            if (panel_lat) begin
                latq.push_back(int'(panel_addr));
                cntq.push_back(ecnt);
                ecnt = 0;
                total_lats++;
            end
            if (!panel_oe_n) run++;
            else if (run > 0) begin
                oeq.push_back(run);
                run = 0;
            end
            if (panel_addr != prev_addr && (!panel_oe_n || prev_oe_low)) addr_viol++;
            prev_addr   = panel_addr;
            prev_oe_low = !panel_oe_n;
            if (frame_done) fdq.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_queues();
        edgeq.delete(); latq.delete(); cntq.delete(); oeq.delete(); fdq.delete();
    endtask

    // Expected plane content straight from the frame buffer: column c, plane p.
    task automatic check_plane(input int row, input int plane);
        int mism = 0;
        logic [23:0] px;
        logic [2:0]  e, x;
        if (edgeq.size() < COLS || latq.size() < 1 || oeq.size() < 1 || cntq.size() < 1) begin
            check($sformatf("plane_r%0d_p%0d_present", row, plane), 0, 1);
            return;
        end
        for (int c = 0; c < COLS; c++) begin
            e  = edgeq.pop_front();
            px = mem[row][c];
            x  = {px[16 + plane], px[8 + plane], px[plane]};
            if (e !== x) mism++;
        end
        check($sformatf("bits_r%0d_p%0d", row, plane), mism, 0);
        check($sformatf("edges_r%0d_p%0d", row, plane), cntq.pop_front(), COLS);
        check($sformatf("lat_addr_r%0d_p%0d", row, plane), latq.pop_front(), row);
        check($sformatf("oe_run_r%0d_p%0d", row, plane), oeq.pop_front(), 1 << plane);
    endtask

    initial begin
        int n;
        logic [7:0] cb;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mem[r][c] = 24'($urandom());
        for (int c = 0; c < COLS; c++) begin
            cb = 8'(c);
            mem[0][c] = {cb, 8'h00, 8'hff};
        end

        // 1: reset state and idle behaviour
        tick(3);
        check("rst_oe_n", panel_oe_n, 1);
        check("rst_pclk", panel_clk, 0);
        check("rst_lat", panel_lat, 0);
        check("rst_addr", panel_addr, 0);
        check("rst_rgb", {panel_r, panel_g, panel_b}, 0);
        check("rst_rowcol", {rrow, rcol}, 0);
        check("rst_fd", frame_done, 0);
        rst = 1'b0;
        tick(100);
        check("idle_edges", total_edges, 0);
        check("idle_lats", total_lats, 0);
        check("idle_oe_n", panel_oe_n, 1);

        // 2-4: free-run three frames
        clear_queues();
        enable = 1'b1;
        n = 0;
        while (fdq.size() < 3 && n < 3 * FRAME + 2000) begin
            tick(1);
            n++;
        end
        check("frames_seen", fdq.size() >= 3, 1);
        tick(20);
        if (fdq.size() >= 3) begin
            check("fd_period_1", fdq[1] - fdq[0], FRAME);
            check("fd_period_2", fdq[2] - fdq[1], FRAME);
        end
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < ROWS; r++)
                for (int p = 0; p < BITS; p++)
                    check_plane(r, p);
        check("addr_vs_oe", addr_viol, 0);

        // 5: drop enable during SHIFT of row 2, plane 3
        rst = 1'b1;
        tick(2);
        clear_queues();
        rst = 1'b0;
        n = 0;
        while (!(latq.size() == 19 && oeq.size() == 19) && n < 5000) begin
            tick(1);
            n++;
        end
        check("reach_r2p3", latq.size() == 19 && oeq.size() == 19, 1);
        tick(10);
        enable = 1'b0;
        tick(300);
        check("drop_lats", latq.size(), 20);
        check("drop_oe_runs", oeq.size(), 20);
        check("drop_edges", edgeq.size(), 20 * COLS);
        check("drop_idle_oe", panel_oe_n, 1);
        check("drop_idle_pclk", panel_clk, 0);
        for (int k = 0; k < 20; k++) check_plane(k / BITS, k % BITS);
        n = total_edges;
        tick(50);
        check("drop_no_edges", total_edges - n, 0);
        enable = 1'b1;
        n = 0;
        while (!(latq.size() >= 1 && oeq.size() >= 1) && n < 500) begin
            tick(1);
            n++;
        end
        check("reenable_lat", latq.size() >= 1, 1);
        check_plane(0, 0);

        // 6: async reset in the middle of a DISPLAY cycle
        n = 0;
        while (panel_oe_n !== 1'b0 && n < 500) begin
            tick(1);
            n++;
        end
        check("found_display", panel_oe_n, 0);
        #2 rst = 1'b1;
        #1;
        check("async_oe_n", panel_oe_n, 1);
        check("async_lat", panel_lat, 0);
        check("async_addr", panel_addr, 0);
        tick(3);
        clear_queues();
        rst = 1'b0;
        n = 0;
        while (!(latq.size() >= 2 && oeq.size() >= 2) && n < 1000) begin
            tick(1);
            n++;
        end
        check("resume_lat", latq.size() >= 2, 1);
        check_plane(0, 0);
        check_plane(0, 1);
        check("addr_vs_oe_end", addr_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
